pattern_modifier_p: RTL and testbench

PATTERN_MODIFIER_P -- requirements
Module: pattern_modifier_p

---
 rtl/pattern_modifier_p.sv | 173 +++++++++++++++++
 tb/tb_pattern_modifier_p.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pattern_modifier_p.sv
// ============================================================================
// Module   : pattern_modifier_p
// Brief    : Two-stage pixel pipeline applying per-frame coordinate and colour
//            effects (mirror, rotate, scroll, invert, fade).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pattern_modifier_p #(
    parameter int XW         = 4,
    parameter int YW         = 4,
    parameter int CW         = 5,
    parameter int NCH        = 1,
    parameter int BW         = 4,
    parameter int SCROLL_DIV = 4
) (
    input  logic              fclock,
    input  logic              init_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sof,
    input  logic [XW-1:0]     xin,
    input  logic [YW-1:0]     yin,
    input  logic [NCH*CW-1:0] rgbin,
    input  logic [2:0]        mode,
    input  logic [BW-1:0]     bright,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XW-1:0]     xout,
    output logic [YW-1:0]     yout,
    output logic [NCH*CW-1:0] rgbout
);

    localparam logic [2:0] M_MIRX   = 3'd1;
    localparam logic [2:0] M_MIRY   = 3'd2;
    localparam logic [2:0] M_ROT180 = 3'd3;
    localparam logic [2:0] M_SCROLL = 3'd4;
    localparam logic [2:0] M_INVERT = 3'd5;
    localparam logic [2:0] M_FADE   = 3'd6;
    localparam logic [7:0] DIV_LAST = 8'(SCROLL_DIV - 1);

    logic              en;
    logic              accept;
    logic              take_sof;

    logic [2:0]        cur_mode;
    logic [BW-1:0]     cur_bright;
    logic [7:0]        frame_cnt;
    logic [XW-1:0]     offset;

    logic [2:0]        eff_mode;
    logic [BW-1:0]     eff_bright;
    logic [7:0]        cnt_inc;
    logic [7:0]        cnt_next;
    logic [XW-1:0]     off_next;
    logic [XW-1:0]     x1;
    logic [YW-1:0]     y1;

    logic              s1_valid;
    logic [XW-1:0]     s1_x;
    logic [YW-1:0]     s1_y;
    logic [NCH*CW-1:0] s1_rgb;
    logic [2:0]        s1_mode;
    logic [BW-1:0]     s1_bright;

    logic [NCH*CW-1:0] faded;
    logic [NCH*CW-1:0] rgb2;

    assign en       = !out_valid | out_ready;
    assign in_ready = en;
    assign accept   = in_valid & en;
    assign take_sof = accept & sof;

    // A sof pixel already sees the mode, brightness and scroll offset it latches.
    always_comb begin
        eff_mode   = take_sof ? mode : cur_mode;
        eff_bright = take_sof ? bright : cur_bright;
        cnt_inc    = (frame_cnt == DIV_LAST) ? 8'd0 : frame_cnt + 8'd1;
        cnt_next   = frame_cnt;
        off_next   = offset;
        if (take_sof) begin
            if (mode == M_SCROLL && cur_mode == M_SCROLL) begin
                cnt_next = cnt_inc;
                if (cnt_inc == DIV_LAST) begin
                    off_next = offset + XW'(1);
                end
            end else begin
                cnt_next = 8'd0;
                off_next = '0;
            end
        end
    end

    always_comb begin
        x1 = xin;
        y1 = yin;
        case (eff_mode)
            M_MIRX:   x1 = ~xin;
            M_MIRY:   y1 = ~yin;
            M_ROT180: begin
                x1 = ~xin;
                y1 = ~yin;
            end
            M_SCROLL: x1 = xin + off_next;
            default:  ;
        endcase
    end

    always_ff @(posedge fclock or negedge init_n) begin
        if (!init_n) begin
            cur_mode   <= 3'd0;
            cur_bright <= '1;
            frame_cnt  <= 8'd0;
            offset     <= '0;
        end else if (take_sof) begin
            cur_mode   <= mode;
            cur_bright <= bright;
            frame_cnt  <= cnt_next;
            offset     <= off_next;
        end
    end

    always_ff @(posedge fclock or negedge init_n) begin
        if (!init_n) begin
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_rgb    <= '0;
            s1_mode   <= 3'd0;
            s1_bright <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_x      <= x1;
            s1_y      <= y1;
            s1_rgb    <= rgbin;
            s1_mode   <= eff_mode;
            s1_bright <= eff_bright;
        end
    end

    // Fade: truncating multiply then drop the brightness fraction bits.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [CW+BW-1:0] prod;
        assign prod                 = (CW+BW)'(s1_rgb[k*CW +: CW]) * (CW+BW)'(s1_bright);
        assign faded[k*CW +: CW]    = CW'(prod >> BW);
    end

    always_comb begin
        rgb2 = s1_rgb;
        case (s1_mode)
            M_INVERT: rgb2 = ~s1_rgb;
            M_FADE:   rgb2 = faded;
            default:  ;
        endcase
    end

    always_ff @(posedge fclock or negedge init_n) begin
        if (!init_n) begin
            out_valid <= 1'b0;
            xout      <= '0;
            yout      <= '0;
            rgbout    <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            xout      <= s1_x;
            yout      <= s1_y;
            rgbout    <= rgb2;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pattern_modifier_p.sv
// ============================================================================
// Module   : tb_pattern_modifier_p
// Brief    : Directed self-checking bench for pattern_modifier_p.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pattern_modifier_p;

    logic       fclock = 1'b0;
    logic       init_n;
    logic       in_valid;
    logic       in_ready;
    logic       sof;
    logic [3:0] xin;
    logic [3:0] yin;
    logic [4:0] rgbin;
    logic [2:0] mode;
    logic [3:0] bright;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] xout;
    logic [3:0] yout;
    logic [4:0] rgbout;

    int checks = 0;
    int errors = 0;

    pattern_modifier_p #(
        .XW(4), .YW(4), .CW(5), .NCH(1), .BW(4), .SCROLL_DIV(2)
    ) dut (
        .fclock(fclock), .init_n(init_n),
        .in_valid(in_valid), .in_ready(in_ready), .sof(sof),
        .xin(xin), .yin(yin), .rgbin(rgbin), .mode(mode), .bright(bright),
        .out_valid(out_valid), .out_ready(out_ready),
        .xout(xout), .yout(yout), .rgbout(rgbout)
    );

    always #5 fclock = ~fclock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One isolated pixel with out_ready high: not valid after 1 edge, valid after 2.
    task automatic pix(input string tag, input logic s, input logic [3:0] x, input logic [3:0] y,
                       input logic [4:0] c, input logic [2:0] m, input logic [3:0] b,
                       input logic [3:0] ex, input logic [3:0] ey, input logic [4:0] ec);
        sof = s; xin = x; yin = y; rgbin = c; mode = m; bright = b; in_valid = 1'b1;
        @(posedge fclock); #1;
        in_valid = 1'b0; sof = 1'b0;
        chk({tag, ".lat1"}, out_valid, 0);
        @(posedge fclock); #1;
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".x"}, xout, ex);
        chk({tag, ".y"}, yout, ey);
        chk({tag, ".rgb"}, rgbout, ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcvd;
        logic [3:0] held;
        logic was_stall;

        init_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sof = 1'b0;
        xin = '0; yin = '0; rgbin = '0; mode = '0; bright = '0;
        #2;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.xout", xout, 0);
        chk("rst.yout", yout, 0);
        chk("rst.rgbout", rgbout, 0);
        chk("rst.in_ready", in_ready, 1);
        repeat (2) @(posedge fclock);
        @(negedge fclock);
        init_n = 1'b1;
        #1;
        chk("rel.in_ready", in_ready, 1);

        pix("pass",     1, 4'd3, 4'd5, 5'd17, 3'd0, 4'd15, 4'd3,  4'd5,  5'd17);
        pix("rot180",   1, 4'd2, 4'd9, 5'd8,  3'd3, 4'd15, 4'd13, 4'd6,  5'd8);
        pix("mirx",     1, 4'd2, 4'd9, 5'd8,  3'd1, 4'd15, 4'd13, 4'd9,  5'd8);
        pix("mirx_nos", 0, 4'd2, 4'd9, 5'd8,  3'd3, 4'd0,  4'd13, 4'd9,  5'd8);
        pix("miry",     1, 4'd2, 4'd9, 5'd8,  3'd2, 4'd15, 4'd2,  4'd6,  5'd8);
        pix("invert",   1, 4'd2, 4'd9, 5'd8,  3'd5, 4'd15, 4'd2,  4'd9,  5'd23);
        pix("fade8",    1, 4'd1, 4'd1, 5'd31, 3'd6, 4'd8,  4'd1,  4'd1,  5'd15);
        pix("fade0",    1, 4'd1, 4'd1, 5'd31, 3'd6, 4'd0,  4'd1,  4'd1,  5'd0);
        pix("fade15",   1, 4'd1, 4'd1, 5'd20, 3'd6, 4'd15, 4'd1,  4'd1,  5'd18);
        pix("fade_nos", 0, 4'd1, 4'd1, 5'd20, 3'd6, 4'd0,  4'd1,  4'd1,  5'd18);
        pix("mode7",    1, 4'd4, 4'd7, 5'd9,  3'd7, 4'd15, 4'd4,  4'd7,  5'd9);

        pix("scr1",     1, 4'd15, 4'd0, 5'd5, 3'd4, 4'd15, 4'd15, 4'd0, 5'd5);
        pix("scr2",     1, 4'd15, 4'd0, 5'd5, 3'd4, 4'd15, 4'd0,  4'd0, 5'd5);
        pix("scr3",     1, 4'd15, 4'd0, 5'd5, 3'd4, 4'd15, 4'd0,  4'd0, 5'd5);
        pix("scr3_nos", 0, 4'd3,  4'd0, 5'd5, 3'd0, 4'd15, 4'd4,  4'd0, 5'd5);
        pix("scr4",     1, 4'd15, 4'd0, 5'd5, 3'd4, 4'd15, 4'd1,  4'd0, 5'd5);
        pix("scr5pass", 1, 4'd15, 4'd0, 5'd5, 3'd0, 4'd15, 4'd15, 4'd0, 5'd5);
        pix("scr_new1", 1, 4'd15, 4'd0, 5'd5, 3'd4, 4'd15, 4'd15, 4'd0, 5'd5);
        pix("scr_new2", 1, 4'd15, 4'd0, 5'd5, 3'd4, 4'd15, 4'd0,  4'd0, 5'd5);

        // Backpressure: continuous stream of x = 0..9 with a 5-cycle stall.
        @(posedge fclock); #1;
        sent = 0; rcvd = 0; held = '0; was_stall = 1'b0;
        for (int cyc = 0; cyc < 60 && rcvd < 10; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            in_valid  = (sent < 10);
            sof       = (sent == 0);
            mode      = 3'd0; bright = 4'd15;
            xin       = sent[3:0]; yin = 4'd2; rgbin = sent[4:0];
            #1;
            if (was_stall) begin
                chk("bp.hold_valid", out_valid, 1);
                chk("bp.hold_x", xout, held);
            end
            if (out_valid && !out_ready) begin
                chk("bp.in_ready_low", in_ready, 0);
                held = xout;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("bp.order_x", xout, rcvd);
                chk("bp.order_rgb", rgbout, rcvd);
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge fclock); #1;
        end
        chk("bp.count", rcvd, 10);
        in_valid = 1'b0; sof = 1'b0; out_ready = 1'b1;
        @(posedge fclock); #1;

        // Reset with two pixels in flight.
        pix("pre_rst", 1, 4'd2, 4'd9, 5'd8, 3'd1, 4'd15, 4'd13, 4'd9, 5'd8);
        in_valid = 1'b1; sof = 1'b0; xin = 4'd3; yin = 4'd1; rgbin = 5'd3;
        @(posedge fclock); #1;
        xin = 4'd4;
        @(posedge fclock); #1;
        chk("rst_mid.pre_valid", out_valid, 1);
        xin = 4'd5;
        init_n = 1'b0;
        #1;
        chk("rst_mid.out_valid", out_valid, 0);
        chk("rst_mid.xout", xout, 0);
        chk("rst_mid.rgbout", rgbout, 0);
        chk("rst_mid.in_ready", in_ready, 1);
        repeat (2) @(posedge fclock);
        in_valid = 1'b0;
        @(negedge fclock);
        init_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge fclock); #1;
            chk("rst_mid.no_stale", out_valid, 0);
        end
        pix("post_rst", 0, 4'd3, 4'd5, 5'd17, 3'd1, 4'd0, 4'd3, 4'd5, 5'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
